// File: rtl/ws2812_right_driver_pkg.sv
// Shared definitions for the right-edge WS2812 LED driver:
// transmitter states, default timing, zone count and colour field slices.
package ws2812_right_driver_pkg;

    // Default frame geometry and WS2812 timing in clkn cycles (148.5 MHz)
    localparam int WS_NUM_LED   = 45;
    localparam int WS_T0H       = 59;
    localparam int WS_T1H       = 119;
    localparam int WS_TBIT      = 186;
    localparam int WS_TRST      = 44550;
    localparam int WS_DIM_SHIFT = 1;

    // Colour field positions inside a 24-bit RGB word
    localparam int R_MSB = 23;
    localparam int R_LSB = 16;
    localparam int G_MSB = 15;
    localparam int G_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_BIT   = 3'd2,
        ST_NEXT  = 3'd3,
        ST_LATCH = 3'd4
    } tx_state_e;

    // Reorder an RGB word into wire order {G,R,B}, shifting each channel right
    function automatic logic [23:0] grb_word(input logic [23:0] rgb, input int shift);
        logic [7:0] r_s;
        logic [7:0] g_s;
        logic [7:0] b_s;
        r_s = rgb[R_MSB:R_LSB] >> shift;
        g_s = rgb[G_MSB:G_LSB] >> shift;
        b_s = rgb[B_MSB:B_LSB] >> shift;
        return {g_s, r_s, b_s};
    endfunction

endpackage

// File: rtl/ws2812_right_driver_bit_tx.sv
// WS2812 word serialiser: on start, sends a 24-bit word MSB first, each bit
// TBIT cycles long with a high time of T0H or T1H. done is high during the
// final cycle of the last bit so the sequencer can move on at that edge.
module ws2812_right_driver_bit_tx
    import ws2812_right_driver_pkg::*;
#(
    parameter int T0H  = WS_T0H,
    parameter int T1H  = WS_T1H,
    parameter int TBIT = WS_TBIT
) (
    input  logic        clkn,
    input  logic        resetn,
    input  logic        start,
    input  logic [23:0] word,
    output logic        led_dout,
    output logic        done
);

    localparam int CNT_W = (TBIT > 1) ? $clog2(TBIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(TBIT - 1);
    localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(TBIT - 2);
    localparam logic [CNT_W-1:0] T0H_C        = CNT_W'(T0H);
    localparam logic [CNT_W-1:0] T1H_C        = CNT_W'(T1H);

    logic             active_r;
    logic [CNT_W-1:0] cnt_r;
    logic [4:0]       bit_idx_r;
    logic [23:0]      shift_r;
    logic             led_dout_r;
    logic             done_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [CNT_W-1:0] high_len_s;

    // Next bit-cycle count and the high time of the bit currently on the wire
    always_comb begin
        cnt_inc_s = cnt_r + CNT_W'(1);
        if (shift_r[23]) begin
            high_len_s = T1H_C;
        end else begin
            high_len_s = T0H_C;
        end
    end

    // Bit timing: output is computed one cycle ahead so led_dout is a flop
    always_ff @(negedge clkn or posedge resetn) begin
        if (resetn) begin
            active_r   <= 1'b0;
            cnt_r      <= '0;
            bit_idx_r  <= 5'd0;
            shift_r    <= 24'd0;
            led_dout_r <= 1'b0;
            done_r     <= 1'b0;
        end else if (start) begin
            active_r   <= 1'b1;
            cnt_r      <= '0;
            bit_idx_r  <= 5'd23;
            shift_r    <= word;
            led_dout_r <= 1'b1;
            done_r     <= 1'b0;
        end else if (active_r) begin
            if (cnt_r == LAST_CNT) begin
                cnt_r <= '0;
                if (bit_idx_r == 5'd0) begin
                    active_r   <= 1'b0;
                    led_dout_r <= 1'b0;
                    done_r     <= 1'b0;
                end else begin
                    shift_r    <= {shift_r[22:0], 1'b0};
                    bit_idx_r  <= bit_idx_r - 5'd1;
                    led_dout_r <= 1'b1;
                    done_r     <= 1'b0;
                end
            end else begin
                cnt_r      <= cnt_inc_s;
                led_dout_r <= (cnt_inc_s < high_len_s);
                done_r     <= (cnt_r == PRE_LAST_CNT) && (bit_idx_r == 5'd0);
            end
        end else begin
            led_dout_r <= 1'b0;
            done_r     <= 1'b0;
        end
    end

    assign led_dout = led_dout_r;
    assign done     = done_r;

endmodule

// File: rtl/ws2812_right_driver.sv
// Right-side ambient LED driver: captures one colour per zone from the zone
// extractor into a double buffer and streams each complete frame onto a
// WS2812 data line (GRB, MSB first) followed by a latch gap.
// Optional build macro WS2812_DIM_EN: channels are shifted right by
// DIM_SHIFT as each word is loaded for transmission.
module ws2812_right_driver
    import ws2812_right_driver_pkg::*;
#(
    parameter int NUM_LED   = WS_NUM_LED,
    parameter int T0H       = WS_T0H,
    parameter int T1H       = WS_T1H,
    parameter int TBIT      = WS_TBIT,
    parameter int TRST      = WS_TRST,
    parameter int DIM_SHIFT = WS_DIM_SHIFT
) (
    input  logic        clkn,
    input  logic        resetn,
    input  logic        vs,
    input  logic        dv_rgb_in,
    input  logic [23:0] rgb_in,
    output logic        led_dout,
    output logic        busy,
    output logic [7:0]  frame_drop_cnt
);

    localparam int IDX_W = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;
    localparam int LAT_W = (TRST > 1) ? $clog2(TRST) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LED - 1);
    localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(TRST - 1);

`ifdef WS2812_DIM_EN
    localparam bit DIM_ON = 1'b1;
`else
    localparam bit DIM_ON = 1'b0;
`endif
    localparam int EFF_SHIFT = DIM_ON ? DIM_SHIFT : 32'sd0;

    tx_state_e        state_r;
    tx_state_e        state_next_s;
    logic [23:0]      frame_buf_r [2][NUM_LED];
    logic             wr_sel_r;
    logic [IDX_W-1:0] wr_idx_r;
    logic [IDX_W-1:0] led_idx_r;
    logic             pending_r;
    logic [7:0]       drop_cnt_r;
    logic             busy_r;
    logic [LAT_W-1:0] latch_cnt_r;
    logic             capture_s;
    logic             complete_s;
    logic             swap_s;
    logic             start_s;
    logic             tx_done_s;
    logic             tx_dout_s;
    logic [23:0]      load_word_s;

    // Capture qualifiers: a zone is taken only during active video, the last
    // zone completes the frame, and an idle transmitter with a frame waiting swaps
    always_comb begin
        capture_s  = dv_rgb_in && !vs;
        complete_s = capture_s && (wr_idx_r == LAST_IDX);
        swap_s     = (state_r == ST_IDLE) && pending_r;
    end

    // Double buffer storage: writes always go to the buffer selected by wr_sel
    always_ff @(negedge clkn or posedge resetn) begin
        if (resetn) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < NUM_LED; i++) begin
                    frame_buf_r[s][i] <= 24'd0;
                end
            end
        end else if (capture_s) begin
            frame_buf_r[wr_sel_r][wr_idx_r] <= rgb_in;
        end
    end

    // Zone write index: parked at 0 in blanking so partial frames are dropped
    always_ff @(negedge clkn or posedge resetn) begin
        if (resetn) begin
            wr_idx_r <= '0;
        end else if (vs) begin
            wr_idx_r <= '0;
        end else if (capture_s) begin
            if (complete_s) begin
                wr_idx_r <= '0;
            end else begin
                wr_idx_r <= wr_idx_r + IDX_W'(1);
            end
        end
    end

    // Frame handoff: swap buffers when idle, track pending and dropped frames.
    // A completion on the swap cycle re-arms pending for the next frame.
    always_ff @(negedge clkn or posedge resetn) begin
        if (resetn) begin
            wr_sel_r   <= 1'b0;
            pending_r  <= 1'b0;
            drop_cnt_r <= 8'd0;
        end else if (swap_s) begin
            wr_sel_r  <= ~wr_sel_r;
            pending_r <= complete_s;
        end else if (complete_s) begin
            pending_r <= 1'b1;
            if (pending_r && (drop_cnt_r != 8'hFF)) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end
        end
    end

    // Word presented to the serialiser: read side of the buffer, wire order
    always_comb begin
        load_word_s = grb_word(frame_buf_r[~wr_sel_r][led_idx_r], EFF_SHIFT);
    end

    // Sequencer state register
    always_ff @(negedge clkn or posedge resetn) begin
        if (resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Sequencer next state and serialiser start strobe
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pending_r) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                start_s      = 1'b1;
                state_next_s = ST_BIT;
            end
            ST_BIT: begin
                if (tx_done_s) begin
                    state_next_s = ST_NEXT;
                end else begin
                    state_next_s = ST_BIT;
                end
            end
            ST_NEXT: begin
                if (led_idx_r == LAST_IDX) begin
                    state_next_s = ST_LATCH;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_LATCH: begin
                if (latch_cnt_r == LAST_LAT) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_LATCH;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // LED index advances between words and rewinds after the last LED
    always_ff @(negedge clkn or posedge resetn) begin
        if (resetn) begin
            led_idx_r <= '0;
        end else if (state_r == ST_NEXT) begin
            if (led_idx_r == LAST_IDX) begin
                led_idx_r <= '0;
            end else begin
                led_idx_r <= led_idx_r + IDX_W'(1);
            end
        end
    end

    // Latch gap timer, cleared whenever the sequencer is outside LATCH
    always_ff @(negedge clkn or posedge resetn) begin
        if (resetn) begin
            latch_cnt_r <= '0;
        end else if (state_r == ST_LATCH) begin
            latch_cnt_r <= latch_cnt_r + LAT_W'(1);
        end else begin
            latch_cnt_r <= '0;
        end
    end

    // Busy flag registered from the next state so it tracks the FSM exactly
    always_ff @(negedge clkn or posedge resetn) begin
        if (resetn) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
        end
    end

    ws2812_right_driver_bit_tx #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_bit_tx (
        .clkn     (clkn),
        .resetn   (resetn),
        .start    (start_s),
        .word     (load_word_s),
        .led_dout (tx_dout_s),
        .done     (tx_done_s)
    );

    assign led_dout       = tx_dout_s;
    assign busy           = busy_r;
    assign frame_drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_ws2812_right_driver.sv
// Self-checking bench for ws2812_right_driver with shortened timing.
// A line monitor decodes led_dout into bits/words and checks pulse timing;
// expected words come from a plain-arithmetic colour model.
module tb_ws2812_right_driver;

    localparam int NL = 3;
    localparam int T0 = 2;
    localparam int T1 = 4;
    localparam int TB = 6;
    localparam int TR = 20;
    localparam int FRAME_CYC = NL * (24 * TB + 2) + TR;

    typedef logic [23:0] frame_t [NL];

    logic        clkn = 1'b0;
    logic        resetn = 1'b1;
    logic        vs = 1'b1;
    logic        dv_rgb_in = 1'b0;
    logic [23:0] rgb_in = 24'd0;
    logic        led_dout;
    logic        busy;
    logic [7:0]  frame_drop_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    int          frames_done = 0;
    logic [23:0] rx_q [$];

    ws2812_right_driver #(
        .NUM_LED   (NL),
        .T0H       (T0),
        .T1H       (T1),
        .TBIT      (TB),
        .TRST      (TR),
        .DIM_SHIFT (1)
    ) dut (
        .clkn           (clkn),
        .resetn         (resetn),
        .vs             (vs),
        .dv_rgb_in      (dv_rgb_in),
        .rgb_in         (rgb_in),
        .led_dout       (led_dout),
        .busy           (busy),
        .frame_drop_cnt (frame_drop_cnt)
    );

    always #5 clkn = ~clkn;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: wire word is G,R,B of the zone colour (halved when dimming)
    function automatic logic [23:0] exp_word(input logic [23:0] rgb);
        int r;
        int g;
        int b;
        r = (rgb >> 16) & 255;
        g = (rgb >> 8) & 255;
        b = rgb & 255;
`ifdef WS2812_DIM_EN
        r = r / 2;
        g = g / 2;
        b = b / 2;
`endif
        return 24'(g * 65536 + r * 256 + b);
    endfunction

    // Line monitor: decodes bits, checks pulse/period/frame timing
    initial begin : line_monitor
        int hi_len;
        int lo_len;
        int busy_len;
        int bit_cnt;
        logic [23:0] word;
        logic prev_led;
        logic prev_busy;
        logic first;
        hi_len = 0; lo_len = 0; busy_len = 0; bit_cnt = 0;
        word = 24'd0; prev_led = 1'b0; prev_busy = 1'b0; first = 1'b1;
        forever begin
            @(posedge clkn);
            if (resetn) begin
                hi_len = 0; lo_len = 0; busy_len = 0; bit_cnt = 0;
                prev_led = 1'b0; prev_busy = 1'b0; first = 1'b1;
            end else begin
                if (busy && !prev_busy) begin
                    busy_len = 0; bit_cnt = 0; lo_len = 0; hi_len = 0; first = 1'b1;
                end
                if (!busy && prev_busy) begin
                    check_eq("busy_cycles", busy_len, FRAME_CYC);
                    check_eq("bits_per_frame", bit_cnt, 24 * NL);
                    check_eq("latch_low", lo_len, TB - hi_len + 1 + TR);
                    frames_done++;
                end
                if (busy) busy_len++;
                if (led_dout) begin
                    if (!prev_led) begin
                        if (first) check_eq("first_rise", lo_len, 1);
                        else check_eq("bit_period", hi_len + lo_len, (bit_cnt % 24 == 0) ? TB + 2 : TB);
                        first = 1'b0;
                        hi_len = 0;
                    end
                    hi_len++;
                    check_eq("led_while_idle", busy, 1);
                end else begin
                    if (prev_led) begin
                        check_eq("high_time", (hi_len == T0) || (hi_len == T1), 1);
                        word = {word[22:0], (hi_len == T1)};
                        bit_cnt++;
                        if (bit_cnt % 24 == 0) rx_q.push_back(word);
                        lo_len = 0;
                    end
                    lo_len++;
                end
                prev_led = led_dout;
                prev_busy = busy;
            end
        end
    end

    task automatic send_zone(input logic [23:0] c);
        @(posedge clkn);
        dv_rgb_in = 1'b1;
        rgb_in = c;
        @(posedge clkn);
        dv_rgb_in = 1'b0;
    endtask

    task automatic send_frame(input frame_t f);
        @(posedge clkn);
        vs = 1'b0;
        for (int i = 0; i < NL; i++) send_zone(f[i]);
        @(posedge clkn);
        vs = 1'b1;
        @(posedge clkn);
    endtask

    task automatic wait_frames(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (frames_done < target && k < budget) begin
            @(posedge clkn);
            k++;
        end
        check_eq({tag, "_timeout"}, frames_done >= target, 1);
    endtask

    task automatic wait_busy(input int budget, input string tag);
        int k;
        k = 0;
        while (!busy && k < budget) begin
            @(posedge clkn);
            k++;
        end
        check_eq({tag, "_busy_timeout"}, busy, 1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k;
        int quiet;
        k = 0;
        quiet = 0;
        while (quiet < 5 && k < budget) begin
            @(posedge clkn);
            k++;
            if (busy) quiet = 0;
            else quiet++;
        end
        check_eq({tag, "_idle_timeout"}, quiet >= 5, 1);
    endtask

    task automatic expect_frame(input frame_t f, input string tag);
        for (int i = 0; i < NL; i++) begin
            if (rx_q.size() > 0) check_eq(tag, rx_q.pop_front(), exp_word(f[i]));
            else check_eq({tag, "_missing"}, rx_q.size(), NL - i);
        end
    endtask

    initial begin : stimulus
        frame_t fa;
        frame_t fb;
        frame_t fc;
        int base;

        // Reset state
        repeat (3) @(posedge clkn);
        check_eq("rst_led", led_dout, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_drop", frame_drop_cnt, 0);
        resetn = 1'b0;
        repeat (3) @(posedge clkn);
        check_eq("post_rst_busy", busy, 0);
        check_eq("post_rst_led", led_dout, 0);

        // Bit timing with a pure-red frame
        for (int i = 0; i < NL; i++) fa[i] = 24'hFF0000;
        send_frame(fa);
        wait_frames(1, 2000, "red");
        expect_frame(fa, "red_word");

        // Dimming pattern plus random colours
        fa[0] = 24'h80FF40;
        fa[1] = 24'($urandom);
        fa[2] = 24'($urandom);
        send_frame(fa);
        wait_frames(2, 2000, "dimpat");
        expect_frame(fa, "dimpat_word");

        // Random frames, each sent while the line is idle
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < NL; i++) fa[i] = 24'($urandom);
            base = frames_done;
            send_frame(fa);
            wait_frames(base + 1, 2000, "rand");
            expect_frame(fa, "rand_word");
        end
        check_eq("no_drop", frame_drop_cnt, 0);

        // dv in blanking ignored, partial frame discarded
        base = frames_done;
        send_zone(24'($urandom));
        send_zone(24'($urandom));
        @(posedge clkn);
        vs = 1'b0;
        send_zone(24'($urandom));
        send_zone(24'($urandom));
        @(posedge clkn);
        vs = 1'b1;
        repeat (40) @(posedge clkn);
        check_eq("partial_busy", busy, 0);
        check_eq("partial_rx", rx_q.size(), 0);
        check_eq("partial_frames", frames_done, base);
        for (int i = 0; i < NL; i++) fa[i] = 24'($urandom);
        send_frame(fa);
        wait_frames(base + 1, 2000, "after_partial");
        expect_frame(fa, "after_partial_word");
        check_eq("after_partial_rx", rx_q.size(), 0);

        // Overrun: B and C complete while A is transmitting
        base = frames_done;
        for (int i = 0; i < NL; i++) begin
            fa[i] = 24'($urandom);
            fb[i] = 24'($urandom);
            fc[i] = 24'($urandom);
        end
        send_frame(fa);
        wait_busy(50, "ovr");
        send_frame(fb);
        send_frame(fc);
        check_eq("ovr_busy_still", busy, 1);
        check_eq("ovr_drop", frame_drop_cnt, 1);
        wait_frames(base + 2, 3000, "ovr");
        expect_frame(fa, "ovr_first");
        expect_frame(fc, "ovr_second");
        check_eq("ovr_rx_empty", rx_q.size(), 0);
        check_eq("ovr_drop_final", frame_drop_cnt, 1);

        // Drop counter saturates at 255
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NL; i++) fb[i] = 24'($urandom);
            send_frame(fb);
        end
        wait_idle(3000, "sat");
        check_eq("drop_saturated", frame_drop_cnt, 255);
        rx_q.delete();

        // Asynchronous reset while a bit is high
        for (int i = 0; i < NL; i++) fa[i] = 24'($urandom) | 24'h008000;
        send_frame(fa);
        wait_busy(50, "rstmid");
        repeat (30) @(posedge clkn);
        begin
            int k;
            k = 0;
            while (!led_dout && k < 50) begin
                @(posedge clkn);
                k++;
            end
        end
        check_eq("pre_reset_led", led_dout, 1);
        #2;
        resetn = 1'b1;
        #1;
        check_eq("async_rst_led", led_dout, 0);
        check_eq("async_rst_busy", busy, 0);
        check_eq("async_rst_drop", frame_drop_cnt, 0);
        @(posedge clkn);
        resetn = 1'b0;
        rx_q.delete();
        repeat (5) @(posedge clkn);
        check_eq("after_rst_busy", busy, 0);
        base = frames_done;
        for (int i = 0; i < NL; i++) fa[i] = 24'($urandom);
        send_frame(fa);
        wait_frames(base + 1, 2000, "after_rst");
        expect_frame(fa, "after_rst_word");
        check_eq("after_rst_drop", frame_drop_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
